// File: rtl/gpr_port_arbiter.sv
// Two-requester, round-robin arbiter for the shared read/write ports of the
// 4 x 8-bit general-purpose register file; one command executes every 2 cycles.
module gpr_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_WIDTH-1:0] rf_read_address,
  output logic [ADDR_WIDTH-1:0] rf_write_address,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  output logic                  rf_write_enable,
  input  logic [DATA_WIDTH-1:0] rf_read_data
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                state;
  logic                  prev_win;
  logic                  cmd_sel;
  logic                  cmd_we;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  logic                  any_req;
  logic                  win;
  logic                  win_we;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;

  // On a tie the requester that did not win last time gets the port.
  assign any_req   = req0 | req1;
  assign win       = (req0 && req1) ? ~prev_win : req1;
  assign win_we    = win ? we1    : we0;
  assign win_addr  = win ? addr1  : addr0;
  assign win_wdata = win ? wdata1 : wdata0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      prev_win        <= 1'b1;
      cmd_sel         <= 1'b0;
      cmd_we          <= 1'b0;
      cmd_addr        <= '0;
      cmd_wdata       <= '0;
      gnt0            <= 1'b0;
      gnt1            <= 1'b0;
      rf_write_enable <= 1'b0;
      rvalid0         <= 1'b0;
      rvalid1         <= 1'b0;
      rdata0          <= '0;
      rdata1          <= '0;
    end else begin
      gnt0            <= 1'b0;
      gnt1            <= 1'b0;
      rf_write_enable <= 1'b0;
      rvalid0         <= 1'b0;
      rvalid1         <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state           <= ACCESS;
            prev_win        <= win;
            cmd_sel         <= win;
            cmd_we          <= win_we;
            cmd_addr        <= win_addr;
            cmd_wdata       <= win_wdata;
            gnt0            <= ~win;
            gnt1            <= win;
            rf_write_enable <= win_we;
          end
        end
        ACCESS: begin
          // Requests are not sampled here, so a held request runs only once.
          state <= IDLE;
          if (!cmd_we) begin
            if (cmd_sel) begin
              rdata1  <= rf_read_data;
              rvalid1 <= 1'b1;
            end else begin
              rdata0  <= rf_read_data;
              rvalid0 <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Register-file address/data come straight from the command register flops.
  assign rf_read_address  = cmd_addr;
  assign rf_write_address = cmd_addr;
  assign rf_write_data    = cmd_wdata;

endmodule

// File: tb/tb_gpr_port_arbiter.sv
// Directed, table-driven bench for gpr_port_arbiter with a behavioural
// 4 x 8-bit register file attached to the rf_* ports.
module tb_gpr_port_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic       req0, req1, we0, we1;
  logic [1:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata0, rdata1;
  logic [1:0] rf_read_address, rf_write_address;
  logic [7:0] rf_write_data;
  logic       rf_write_enable;
  logic [7:0] rf_read_data;

  logic [7:0] rf [0:3] = '{8'h00, 8'h00, 8'h00, 8'h00};

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  always @(posedge clock)
    if (rf_write_enable) rf[rf_write_address] <= rf_write_data;
  assign rf_read_data = rf[rf_read_address];

  gpr_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) dut (
    .clock           (clock),
    .reset           (reset),
    .req0            (req0),
    .req1            (req1),
    .we0             (we0),
    .we1             (we1),
    .addr0           (addr0),
    .addr1           (addr1),
    .wdata0          (wdata0),
    .wdata1          (wdata1),
    .gnt0            (gnt0),
    .gnt1            (gnt1),
    .rvalid0         (rvalid0),
    .rvalid1         (rvalid1),
    .rdata0          (rdata0),
    .rdata1          (rdata1),
    .rf_read_address (rf_read_address),
    .rf_write_address(rf_write_address),
    .rf_write_data   (rf_write_data),
    .rf_write_enable (rf_write_enable),
    .rf_read_data    (rf_read_data)
  );

  typedef struct {
    int r0, w0, a0, d0;
    int r1, w1, a1, d1;
    int g0, g1, v0, v1, we, ea, ed, rd0, rd1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t V(int r0, int w0, int a0, int d0,
                             int r1, int w1, int a1, int d1,
                             int g0, int g1, int v0, int v1, int we,
                             int ea, int ed, int rd0, int rd1);
    vec_t v;
    v = '{r0, w0, a0, d0, r1, w1, a1, d1, g0, g1, v0, v1, we, ea, ed, rd0, rd1};
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input vec_t v);
    req0   = v.r0[0];
    we0    = v.w0[0];
    addr0  = v.a0[1:0];
    wdata0 = v.d0[7:0];
    req1   = v.r1[0];
    we1    = v.w1[0];
    addr1  = v.a1[1:0];
    wdata1 = v.d1[7:0];
  endtask

  task automatic idle_inputs();
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    #12;
    chk("reset.gnt0", gnt0, 0);
    chk("reset.gnt1", gnt1, 0);
    chk("reset.rvalid0", rvalid0, 0);
    chk("reset.rvalid1", rvalid1, 0);
    chk("reset.rdata0", rdata0, 0);
    chk("reset.rdata1", rdata1, 0);
    chk("reset.wen", rf_write_enable, 0);
    chk("reset.waddr", rf_write_address, 0);
    chk("reset.raddr", rf_read_address, 0);
    chk("reset.wdata", rf_write_data, 0);
    step();
    reset = 1'b0;

    //            r0 w0 a0 d0     r1 w1 a1 d1   g0 g1 v0 v1 we ea ed     rd0    rd1
    // single write, then read-back from requester 1
    vecs.push_back(V(1, 1, 2, 'hA5, 0, 0, 0, 0,  1, 0, 0, 0, 1, 2, 'hA5, 0,     0));
    vecs.push_back(V(1, 1, 2, 'hA5, 0, 0, 0, 0,  0, 0, 0, 0, 0, 2, 'hA5, 0,     0));
    vecs.push_back(V(0, 0, 0, 0,    1, 0, 2, 0,  0, 1, 0, 0, 0, 2, 0,    0,     0));
    vecs.push_back(V(0, 0, 0, 0,    1, 0, 2, 0,  0, 0, 0, 1, 0, 2, 0,    0,     'hA5));
    // sweep: requester 0 fills 0..3
    vecs.push_back(V(1, 1, 0, 'h10, 0, 0, 0, 0,  1, 0, 0, 0, 1, 0, 'h10, 0,     'hA5));
    vecs.push_back(V(1, 1, 0, 'h10, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 'h10, 0,     'hA5));
    vecs.push_back(V(1, 1, 1, 'h11, 0, 0, 0, 0,  1, 0, 0, 0, 1, 1, 'h11, 0,     'hA5));
    vecs.push_back(V(1, 1, 1, 'h11, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 'h11, 0,     'hA5));
    vecs.push_back(V(1, 1, 2, 'h12, 0, 0, 0, 0,  1, 0, 0, 0, 1, 2, 'h12, 0,     'hA5));
    vecs.push_back(V(1, 1, 2, 'h12, 0, 0, 0, 0,  0, 0, 0, 0, 0, 2, 'h12, 0,     'hA5));
    vecs.push_back(V(1, 1, 3, 'h13, 0, 0, 0, 0,  1, 0, 0, 0, 1, 3, 'h13, 0,     'hA5));
    vecs.push_back(V(1, 1, 3, 'h13, 0, 0, 0, 0,  0, 0, 0, 0, 0, 3, 'h13, 0,     'hA5));
    // sweep: requester 1 reads 0..3
    vecs.push_back(V(0, 0, 0, 0,    1, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0,    0,     'hA5));
    vecs.push_back(V(0, 0, 0, 0,    1, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0,    0,     'h10));
    vecs.push_back(V(0, 0, 0, 0,    1, 0, 1, 0,  0, 1, 0, 0, 0, 1, 0,    0,     'h10));
    vecs.push_back(V(0, 0, 0, 0,    1, 0, 1, 0,  0, 0, 0, 1, 0, 1, 0,    0,     'h11));
    vecs.push_back(V(0, 0, 0, 0,    1, 0, 2, 0,  0, 1, 0, 0, 0, 2, 0,    0,     'h11));
    vecs.push_back(V(0, 0, 0, 0,    1, 0, 2, 0,  0, 0, 0, 1, 0, 2, 0,    0,     'h12));
    vecs.push_back(V(0, 0, 0, 0,    1, 0, 3, 0,  0, 1, 0, 0, 0, 3, 0,    0,     'h12));
    vecs.push_back(V(0, 0, 0, 0,    1, 0, 3, 0,  0, 0, 0, 1, 0, 3, 0,    0,     'h13));
    // tie fairness: both read continuously, last winner was requester 1
    vecs.push_back(V(1, 0, 0, 0,    1, 0, 1, 0,  1, 0, 0, 0, 0, 0, 0,    0,     'h13));
    vecs.push_back(V(1, 0, 0, 0,    1, 0, 1, 0,  0, 0, 1, 0, 0, 0, 0,    'h10,  'h13));
    vecs.push_back(V(1, 0, 0, 0,    1, 0, 1, 0,  0, 1, 0, 0, 0, 1, 0,    'h10,  'h13));
    vecs.push_back(V(1, 0, 0, 0,    1, 0, 1, 0,  0, 0, 0, 1, 0, 1, 0,    'h10,  'h11));
    vecs.push_back(V(1, 0, 0, 0,    1, 0, 1, 0,  1, 0, 0, 0, 0, 0, 0,    'h10,  'h11));
    vecs.push_back(V(1, 0, 0, 0,    1, 0, 1, 0,  0, 0, 1, 0, 0, 0, 0,    'h10,  'h11));
    // requester 1 alone, so requester 0 is next in line on a tie
    vecs.push_back(V(0, 0, 0, 0,    1, 0, 1, 0,  0, 1, 0, 0, 0, 1, 0,    'h10,  'h11));
    vecs.push_back(V(0, 0, 0, 0,    1, 0, 1, 0,  0, 0, 0, 1, 0, 1, 0,    'h10,  'h11));
    // write 3C to addr 1 from 0 races read of addr 1 from 1
    vecs.push_back(V(1, 1, 1, 'h3C, 1, 0, 1, 0,  1, 0, 0, 0, 1, 1, 'h3C, 'h10,  'h11));
    vecs.push_back(V(1, 1, 1, 'h3C, 1, 0, 1, 0,  0, 0, 0, 0, 0, 1, 'h3C, 'h10,  'h11));
    vecs.push_back(V(0, 0, 0, 0,    1, 0, 1, 0,  0, 1, 0, 0, 0, 1, 0,    'h10,  'h11));
    vecs.push_back(V(0, 0, 0, 0,    1, 0, 1, 0,  0, 0, 0, 1, 0, 1, 0,    'h10,  'h3C));
    vecs.push_back(V(0, 0, 0, 0,    0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0,    'h10,  'h3C));

    foreach (vecs[i]) begin
      drive(vecs[i]);
      step();
      chk($sformatf("row%0d.gnt0", i), gnt0, vecs[i].g0);
      chk($sformatf("row%0d.gnt1", i), gnt1, vecs[i].g1);
      chk($sformatf("row%0d.rvalid0", i), rvalid0, vecs[i].v0);
      chk($sformatf("row%0d.rvalid1", i), rvalid1, vecs[i].v1);
      chk($sformatf("row%0d.wen", i), rf_write_enable, vecs[i].we);
      chk($sformatf("row%0d.waddr", i), rf_write_address, vecs[i].ea);
      chk($sformatf("row%0d.raddr", i), rf_read_address, vecs[i].ea);
      chk($sformatf("row%0d.wdata", i), rf_write_data, vecs[i].ed);
      chk($sformatf("row%0d.rdata0", i), rdata0, vecs[i].rd0);
      chk($sformatf("row%0d.rdata1", i), rdata1, vecs[i].rd1);
    end

    // reset asserted during the ACCESS cycle of a read from requester 0
    idle_inputs();
    req0 = 1; addr0 = 3;
    step();
    chk("abort.gnt0_before", gnt0, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("abort.gnt0", gnt0, 0);
    chk("abort.wen", rf_write_enable, 0);
    chk("abort.rdata0", rdata0, 0);
    chk("abort.rdata1", rdata1, 0);
    req0 = 0;
    #1;
    reset = 1'b0;
    step();
    chk("abort.rvalid0_a", rvalid0, 0);
    step();
    chk("abort.rvalid0_b", rvalid0, 0);
    chk("abort.gnt_idle", gnt0 | gnt1, 0);

    // first tie after reset goes to requester 0
    req0 = 1; addr0 = 0; req1 = 1; addr1 = 1;
    step();
    chk("post_reset.gnt0", gnt0, 1);
    chk("post_reset.gnt1", gnt1, 0);
    step();
    chk("post_reset.rvalid0", rvalid0, 1);
    chk("post_reset.rdata0", rdata0, 'h10);
    idle_inputs();
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpr_port_arbiter.md
# gpr_port_arbiter

Two-requester arbiter that shares the single read port and single write port of the 4 x 8-bit general-purpose register file. It accepts one read or write command at a time from either requester, applies it to the register file, and returns read data with a valid pulse. Round-robin fairness prevents starvation. It sits between the register file and its two clients, such as the instruction sequencer and a debug/load port.

## Interface
- DATA_WIDTH, 8: register width.
- ADDR_WIDTH, 2: register address width (4 registers).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- req0, req1  in  1  command request from requester 0 / 1.
- we0, we1  in  1  1 = write, 0 = read; qualified by reqN.
- addr0, addr1  in  ADDR_WIDTH  target register.
- wdata0, wdata1  in  DATA_WIDTH  write data; ignored for reads.
- gnt0, gnt1  out  1  one-cycle pulse: the command is being executed this cycle.
- rvalid0, rvalid1  out  1  one-cycle pulse: rdataN holds fresh read data.
- rdata0, rdata1  out  DATA_WIDTH  read data, registered.
- rf_read_address  out  ADDR_WIDTH  to register file read_address.
- rf_write_address  out  ADDR_WIDTH  to register file write_address.
- rf_write_data  out  DATA_WIDTH  to register file write_data.
- rf_write_enable  out  1  to register file write_enable.
- rf_read_data  in  DATA_WIDTH  from register file read_data (combinational read).

## Operation
- FSM has two states: IDLE and ACCESS.
- **IDLE:**
  - No request: stay in IDLE.
  - Any reqN high at the clock edge: latch the winner's we, addr and wdata into the command register, record the winner, and go to ACCESS.
- **Winner selection:**
  - Only one request high: that requester wins.
  - Both high: the requester that was not the previous winner wins.
  - The previous-winner pointer resets to 1, so requester 0 wins the first tie.
- **ACCESS (always exactly one cycle, then IDLE):**
  - gntN = 1 for the winner only.
  - Write: rf_write_enable = 1, rf_write_address and rf_write_data come from the command register.
  - Read: rf_read_address comes from the command register. rf_read_data is captured into rdataN at the end of ACCESS.
  - reqN is ignored during ACCESS. No new command is accepted here.
- **Requester protocol:**
  - Hold reqN, weN, addrN and wdataN stable from assertion until gntN is seen.
  - Drop or change them at the edge that ends the gnt cycle.
  - The arbiter never samples a request during ACCESS, so a held request is not double-executed.
- **Register-file ports:**
  - rf_write_enable is high only in write ACCESS cycles.
  - rf address and data outputs are driven from the command register and hold their last value otherwise.
- **rdataN:** holds its value until the next read completes for that requester. Writes never change rdataN.

## Timing
- Reset values: state IDLE, previous-winner pointer 1, command register 0, and all of the following 0: gnt0/1, rvalid0/1, rdata0/1, rf_read_address, rf_write_address, rf_write_data, rf_write_enable.
- Reset is asynchronous. Asserting it during ACCESS drops rf_write_enable and gnt immediately and aborts the command; completion of an aborted write is not guaranteed. No rvalid is produced for an aborted read.
- Latency:
  - req high in cycle N (state IDLE) -> gnt in cycle N+1.
  - Write: register updated by the end of N+1.
  - Read: rdata/rvalid in N+2.
- Throughput: at most one command per 2 cycles. rvalid for command k coincides with the IDLE cycle that samples command k+1.
- gnt and rvalid are registered, glitch-free outputs driven from state flops.
- Read-after-write: a read granted after a write to the same address returns the new data, because the write completes in an earlier ACCESS cycle.

## Test plan
- Single write: req0=1, we0=1, addr0=2, wdata0=8'hA5 -> gnt0 one cycle later with rf_write_enable=1, rf_write_address=2, rf_write_data=8'hA5 for exactly one cycle; gnt1 stays 0.
- Read-back: after the write above, req1=1, we1=0, addr1=2 -> gnt1 after 1 cycle, rvalid1 pulse after 2 cycles with rdata1=8'hA5; rdata0 unchanged.
- Tie fairness: req0 and req1 held high continuously, both reads, addr0=0, addr1=1 -> grants alternate 0,1,0,1 starting with 0, one every 2 cycles; each rvalidN returns its own register's contents.
- Sweep: fill registers 0..3 with 8'h10..8'h13 from requester 0, then read 0..3 from requester 1 -> rdata1 = 8'h10, 8'h11, 8'h12, 8'h13 in order.
- Reset mid-operation: assert reset in the ACCESS cycle of a read -> gnt, rf_write_enable and rdata drop to 0 immediately; no rvalid follows; after release, the next tie is won by requester 0.
- Write-then-read same address from different requesters in consecutive grants: req0 writes 8'h3C to addr 1 while req1 reads addr 1, both raised in the same cycle -> write granted first, and rdata1 = 8'h3C.
